// File: rtl/tlb_maint_if.sv
// Maintenance-port bundle for tlb_maint_ctrl: pipeline ops, read results, range flush and TLB side.
// The slave modport is the controller's view; the master modport is the requester/TLB environment's view.
interface tlb_maint_if;
   logic [31:0] cur_pid;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_kind;
   logic [31:0] op_addr;
   logic [31:0] op_pid;
   logic [26:0] op_data;
   logic        rd_valid;
   logic [26:0] rd_data;
   logic        rng_start;
   logic [31:0] rng_base;
   logic [15:0] rng_count;
   logic [31:0] rng_pid;
   logic        busy;
   logic        flush_done;
   logic [31:0] tlb_read_addr;
   logic        tlb_we;
   logic        tlb_invalidate;
   logic        tlb_clear;
   logic [31:0] tlb_write_data;
   logic [31:0] tlb_pid;
   logic [26:0] tlb_rd_in;

   modport slave (
      input  cur_pid, op_valid, op_kind, op_addr, op_pid, op_data,
             rng_start, rng_base, rng_count, rng_pid, tlb_rd_in,
      output op_ready, rd_valid, rd_data, busy, flush_done,
             tlb_read_addr, tlb_we, tlb_invalidate, tlb_clear, tlb_write_data, tlb_pid
   );

   modport master (
      output cur_pid, op_valid, op_kind, op_addr, op_pid, op_data,
             rng_start, rng_base, rng_count, rng_pid, tlb_rd_in,
      input  op_ready, rd_valid, rd_data, busy, flush_done,
             tlb_read_addr, tlb_we, tlb_invalidate, tlb_clear, tlb_write_data, tlb_pid
   );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// Arbitrates the TLB maintenance port between pipeline TLB ops and a range-flush engine.
// Optional macro TLB_MAINT_FAIRNESS_EN adds a starvation guard that briefly blocks the pipeline.
module tlb_maint_ctrl #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   tlb_maint_if.slave bus
);
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_INVAL = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_starve_limit
      $error("STARVE_LIMIT must lie in 1..255");
   end

   state_t      r_state;
   logic [19:0] r_vpn;
   logic [15:0] r_remaining;
   logic [31:0] r_flush_pid;
   logic        r_op_ready;
   logic        r_rd_pend;
   logic        r_rd_valid;
   logic        r_busy;
   logic        r_flush_done;
   logic        r_tlb_we;
   logic        r_tlb_inv;
   logic        r_tlb_clear;
   logic [31:0] r_tlb_addr;
   logic [31:0] r_tlb_wdata;
   logic [31:0] r_tlb_pid;
`ifdef TLB_MAINT_FAIRNESS_EN
   localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);
   logic [7:0]  r_starve;
`endif

   logic w_grant;
   logic w_unused;

   assign w_grant  = bus.op_valid && r_op_ready;
   // page offsets never reach the TLB command path
   assign w_unused = &{1'b0, bus.op_addr[11:0], bus.rng_base[11:0]};

   // Command register, read-latency pipe and flush sequencer; everything holds while clk_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_vpn        <= 20'd0;
         r_remaining  <= 16'd0;
         r_flush_pid  <= 32'd0;
         r_op_ready   <= 1'b0;
         r_rd_pend    <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_flush_done <= 1'b0;
         r_tlb_we     <= 1'b0;
         r_tlb_inv    <= 1'b0;
         r_tlb_clear  <= 1'b0;
         r_tlb_addr   <= 32'd0;
         r_tlb_wdata  <= 32'd0;
         r_tlb_pid    <= 32'd0;
`ifdef TLB_MAINT_FAIRNESS_EN
         r_starve     <= 8'd0;
`endif
      end else if (clk_en) begin
         r_tlb_we     <= 1'b0;
         r_tlb_inv    <= 1'b0;
         r_tlb_clear  <= 1'b0;
         r_flush_done <= 1'b0;
         r_tlb_pid    <= bus.cur_pid;
         r_op_ready   <= 1'b1;
         r_rd_pend    <= 1'b0;
         r_rd_valid   <= r_rd_pend;

         if (w_grant) begin
            r_tlb_addr <= {bus.op_addr[31:12], 12'h000};
            r_tlb_pid  <= bus.op_pid;
            case (bus.op_kind)
               OP_READ:  r_rd_pend <= 1'b1;
               OP_WRITE: begin
                  r_tlb_we    <= 1'b1;
                  r_tlb_wdata <= {5'd0, bus.op_data};
               end
               OP_INVAL: r_tlb_inv   <= 1'b1;
               OP_CLEAR: r_tlb_clear <= 1'b1;
               default:  r_rd_pend   <= 1'b0;
            endcase
         end

         case (r_state)
            ST_IDLE: begin
               if (bus.rng_start) begin
                  r_vpn       <= bus.rng_base[31:12];
                  r_remaining <= bus.rng_count;
                  r_flush_pid <= bus.rng_pid;
                  if (bus.rng_count == 16'd0) begin
                     r_flush_done <= 1'b1;
                  end else begin
                     r_state <= ST_FLUSH;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               if (w_grant && (bus.op_kind == OP_CLEAR)) begin
                  // a clear wipes everything the flush would have touched
                  r_state      <= ST_IDLE;
                  r_busy       <= 1'b0;
                  r_flush_done <= 1'b1;
`ifdef TLB_MAINT_FAIRNESS_EN
                  r_starve     <= 8'd0;
`endif
               end else if (w_grant) begin
`ifdef TLB_MAINT_FAIRNESS_EN
                  r_starve <= r_starve + 8'd1;
                  if ((r_starve + 8'd1) == LP_STARVE_LIMIT) begin
                     r_op_ready <= 1'b0;
                  end else begin
                     r_op_ready <= 1'b1;
                  end
`endif
               end else begin
                  r_tlb_addr  <= {r_vpn, 12'h000};
                  r_tlb_pid   <= r_flush_pid;
                  r_tlb_inv   <= 1'b1;
                  r_vpn       <= r_vpn + 20'd1;
                  r_remaining <= r_remaining - 16'd1;
`ifdef TLB_MAINT_FAIRNESS_EN
                  r_starve    <= 8'd0;
`endif
                  if (r_remaining == 16'd1) begin
                     r_state      <= ST_IDLE;
                     r_busy       <= 1'b0;
                     r_flush_done <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.op_ready       = r_op_ready;
   assign bus.rd_valid       = r_rd_valid;
   assign bus.rd_data        = r_rd_valid ? bus.tlb_rd_in : 27'd0;
   assign bus.busy           = r_busy;
   assign bus.flush_done     = r_flush_done;
   assign bus.tlb_read_addr  = r_tlb_addr;
   assign bus.tlb_we         = r_tlb_we;
   assign bus.tlb_invalidate = r_tlb_inv;
   assign bus.tlb_clear      = r_tlb_clear;
   assign bus.tlb_write_data = r_tlb_wdata;
   assign bus.tlb_pid        = r_tlb_pid;
endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Bench for tlb_maint_ctrl: directed test-plan cases plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_tlb_maint_ctrl;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic clk_en = 1'b1;
   always #5 clk = ~clk;

   tlb_maint_if bus();

   tlb_maint_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [51:0] key(input logic [31:0] p, input logic [19:0] v);
      return {p, v};
   endfunction

   // stand-in TLB: synchronous lookup, commands applied on the enabled edge
   logic [26:0] tlb_mem [logic [51:0]];
   logic [26:0] tlb_q = 27'd0;
   assign bus.tlb_rd_in = tlb_q;
   initial begin : tlb_standin
      logic [51:0] k;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            tlb_mem.delete();
            tlb_q = 27'd0;
         end else if (clk_en) begin
            k = key(bus.tlb_pid, bus.tlb_read_addr[31:12]);
            tlb_q = tlb_mem.exists(k) ? tlb_mem[k] : 27'd0;
            if (bus.tlb_clear) tlb_mem.delete();
            else if (bus.tlb_invalidate) tlb_mem.delete(k);
            else if (bus.tlb_we) tlb_mem[k] = bus.tlb_write_data[26:0];
         end
      end
   end

   // model: expected outputs for the cycle currently shown, plus flush/read bookkeeping
   logic        e_ready, e_rdv, e_busy, e_done, e_we, e_inv, e_clr;
   logic [26:0] e_rdd;
   logic [31:0] e_addr, e_wdata, e_pid;
   bit          m_flush;
   int unsigned m_vpn, m_left;
   logic [31:0] m_fpid;
   int          m_starve;
   bit          m_rd1_v;
   logic [26:0] m_rd1_d;
   logic [26:0] mirror [logic [51:0]];

   task automatic model_reset();
      e_ready = 1'b0; e_rdv = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_we = 1'b0; e_inv = 1'b0; e_clr = 1'b0; e_rdd = 27'd0;
      e_addr = 32'd0; e_wdata = 32'd0; e_pid = 32'd0;
      m_flush = 1'b0; m_vpn = 0; m_left = 0; m_fpid = 32'd0; m_starve = 0;
      m_rd1_v = 1'b0; m_rd1_d = 27'd0;
      mirror.delete();
   endtask

   task automatic model_update();
      bit          grant;
      logic [51:0] k;
      if (!clk_en) return;
      grant = bus.op_valid && e_ready;
      e_rdv = m_rd1_v; e_rdd = m_rd1_d; m_rd1_v = 1'b0;
      e_we = 1'b0; e_inv = 1'b0; e_clr = 1'b0; e_done = 1'b0;
      e_pid = bus.cur_pid; e_ready = 1'b1;
      if (grant) begin
         e_addr = {bus.op_addr[31:12], 12'h000};
         e_pid  = bus.op_pid;
         k = key(bus.op_pid, bus.op_addr[31:12]);
         case (bus.op_kind)
            2'd0: begin m_rd1_v = 1'b1; m_rd1_d = mirror.exists(k) ? mirror[k] : 27'd0; end
            2'd1: begin e_we = 1'b1; e_wdata = {5'd0, bus.op_data}; mirror[k] = bus.op_data; end
            2'd2: begin e_inv = 1'b1; mirror.delete(k); end
            default: begin e_clr = 1'b1; mirror.delete(); end
         endcase
      end
      if (!m_flush) begin
         if (bus.rng_start) begin
            m_vpn = 32'(bus.rng_base[31:12]); m_left = 32'(bus.rng_count); m_fpid = bus.rng_pid;
            if (m_left == 0) e_done = 1'b1;
            else m_flush = 1'b1;
         end
      end else if (grant && bus.op_kind == 2'd3) begin
         m_flush = 1'b0; e_done = 1'b1; m_starve = 0;
      end else if (grant) begin
         m_starve++;
`ifdef TLB_MAINT_FAIRNESS_EN
         if (m_starve == LIMIT) e_ready = 1'b0;
`endif
      end else begin
         e_inv = 1'b1; e_addr = {m_vpn[19:0], 12'h000}; e_pid = m_fpid;
         mirror.delete(key(m_fpid, m_vpn[19:0]));
         m_vpn = (m_vpn + 1) % (1 << 20);
         m_left--; m_starve = 0;
         if (m_left == 0) begin m_flush = 1'b0; e_done = 1'b1; end
      end
      e_busy = m_flush;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s @%0t: actual %h required %h", name, $time, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic check_all();
      chk1("op_ready", bus.op_ready, e_ready);
      chk1("rd_valid", bus.rd_valid, e_rdv);
      chk("rd_data", {5'd0, bus.rd_data}, e_rdv ? {5'd0, e_rdd} : 32'd0);
      chk1("busy", bus.busy, e_busy);
      chk1("flush_done", bus.flush_done, e_done);
      chk1("tlb_we", bus.tlb_we, e_we);
      chk1("tlb_invalidate", bus.tlb_invalidate, e_inv);
      chk1("tlb_clear", bus.tlb_clear, e_clr);
      chk("tlb_read_addr", bus.tlb_read_addr, e_addr);
      chk("tlb_write_data", bus.tlb_write_data, e_wdata);
      chk("tlb_pid", bus.tlb_pid, e_pid);
   endtask

   // inputs are set at a falling edge; the model consumes them, then the next falling edge is compared
   task automatic step();
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_inputs();
      bus.op_valid = 1'b0; bus.op_kind = 2'd0; bus.op_addr = 32'd0; bus.op_pid = 32'd0;
      bus.op_data = 27'd0; bus.rng_start = 1'b0; bus.rng_base = 32'd0;
      bus.rng_count = 16'd0; bus.rng_pid = 32'd0;
   endtask

   task automatic op(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] pid,
                     input logic [26:0] data);
      bus.op_valid = 1'b1; bus.op_kind = kind; bus.op_addr = addr; bus.op_pid = pid; bus.op_data = data;
   endtask

   task automatic start_flush(input logic [31:0] base, input logic [15:0] cnt, input logic [31:0] pid);
      bus.rng_start = 1'b1; bus.rng_base = base; bus.rng_count = cnt; bus.rng_pid = pid;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int inv_seen;
      int rdy_low;
      int r;
      bus.cur_pid = 32'h0000_00AA;
      idle_inputs();
      model_reset();
      #2 rst_n = 1'b0;
      #10;
      check_all();
      chk1("rst_op_ready", bus.op_ready, 1'b0);
      chk("rst_addr", bus.tlb_read_addr, 32'd0);
      chk("rst_pid", bus.tlb_pid, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk1("ready_after_rst", bus.op_ready, 1'b1);

      // write then read back
      op(2'd1, 32'h0040_3000, 32'd5, 27'h0012017);
      step();
      chk1("wr_we", bus.tlb_we, 1'b1);
      chk("wr_addr", bus.tlb_read_addr, 32'h0040_3000);
      chk("wr_data", bus.tlb_write_data, 32'h0001_2017);
      chk("wr_pid", bus.tlb_pid, 32'd5);
      op(2'd0, 32'h0040_3000, 32'd5, 27'd0);
      step();
      chk1("rd_not_yet", bus.rd_valid, 1'b0);
      idle_inputs();
      step();
      chk1("rd_valid", bus.rd_valid, 1'b1);
      chk("rd_data", {5'd0, bus.rd_data}, 32'h0001_2017);
      step();
      chk1("rd_pulse_end", bus.rd_valid, 1'b0);

      // three-page flush
      start_flush(32'h0001_0000, 16'd3, 32'd7);
      step();
      idle_inputs();
      chk1("fl_busy", bus.busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("fl_inv", bus.tlb_invalidate, 1'b1);
         chk("fl_addr", bus.tlb_read_addr, 32'h0001_0000 + 32'(i) * 32'h1000);
         chk("fl_pid", bus.tlb_pid, 32'd7);
         chk1("fl_done", bus.flush_done, (i == 2) ? 1'b1 : 1'b0);
      end
      chk1("fl_busy_end", bus.busy, 1'b0);
      step();

      // wrap at the top of the VPN space
      start_flush(32'hFFFF_F000, 16'd2, 32'd1);
      step();
      idle_inputs();
      step();
      chk("wrap_a0", bus.tlb_read_addr, 32'hFFFF_F000);
      step();
      chk("wrap_a1", bus.tlb_read_addr, 32'h0000_0000);
      chk1("wrap_done", bus.flush_done, 1'b1);

      // zero-length flush
      start_flush(32'h0005_0000, 16'd0, 32'd2);
      step();
      idle_inputs();
      chk1("c0_done", bus.flush_done, 1'b1);
      chk1("c0_busy", bus.busy, 1'b0);
      chk1("c0_inv", bus.tlb_invalidate, 1'b0);
      step();
      chk1("c0_done_end", bus.flush_done, 1'b0);

      // clear aborts a long flush
      start_flush(32'h0020_0000, 16'd100, 32'd9);
      step();
      idle_inputs();
      inv_seen = 0;
      for (int i = 0; i < 30 && inv_seen < 10; i++) begin
         step();
         if (bus.tlb_invalidate) inv_seen++;
      end
      chk("abort_inv_before", 32'(inv_seen), 32'd10);
      op(2'd3, 32'd0, 32'd9, 27'd0);
      step();
      idle_inputs();
      chk1("abort_clear", bus.tlb_clear, 1'b1);
      chk1("abort_done", bus.flush_done, 1'b1);
      chk1("abort_busy", bus.busy, 1'b0);
      inv_seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus.tlb_invalidate) inv_seen++;
      end
      chk("abort_no_inv", 32'(inv_seen), 32'd0);

      // pipeline held busy during a flush
      start_flush(32'h0030_0000, 16'd20, 32'd3);
      step();
      inv_seen = 0; rdy_low = 0;
      for (int i = 0; i < 10; i++) begin
         idle_inputs();
         op(2'd0, {20'(i), 12'h000}, 32'd3, 27'd0);
         step();
         if (bus.tlb_invalidate) inv_seen++;
         if (!bus.op_ready) rdy_low++;
      end
`ifdef TLB_MAINT_FAIRNESS_EN
      chk("fair_inv", 32'(inv_seen), 32'd2);
      chk("fair_rdy_low", 32'(rdy_low), 32'd2);
`else
      chk("strict_inv", 32'(inv_seen), 32'd0);
      chk("strict_rdy_low", 32'(rdy_low), 32'd0);
`endif
      idle_inputs();
      for (int i = 0; i < 40 && m_flush; i++) step();
      chk1("fair_drain", bus.busy, 1'b0);

      // reset in the middle of a flush
      start_flush(32'h0040_0000, 16'd50, 32'd4);
      step();
      idle_inputs();
      for (int i = 0; i < 5; i++) step();
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_busy", bus.busy, 1'b0);
      chk1("mid_rst_done", bus.flush_done, 1'b0);
      chk1("mid_rst_inv", bus.tlb_invalidate, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      check_all();
      for (int i = 0; i < 4; i++) step();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         clk_en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 2) == 0) begin
            r = int'($urandom_range(0, 15));
            op((r < 6) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3,
               {20'($urandom_range(0, 15)), 12'($urandom)}, 32'($urandom_range(0, 2)), 27'($urandom));
         end
         if ($urandom_range(0, 19) == 0) begin
            start_flush({($urandom_range(0, 3) == 0) ? 20'hFFFFE : 20'($urandom_range(0, 12)), 12'($urandom)},
                        16'($urandom_range(0, 12)), 32'($urandom_range(0, 2)));
         end
         if ($urandom_range(0, 49) == 0) bus.cur_pid = $urandom;
         step();
      end
      idle_inputs();
      clk_en = 1'b1;
      for (int i = 0; i < 100 && m_flush; i++) step();
      step();
      chk1("final_busy", bus.busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
